fft_pipe_sequencer: RTL and testbench

//  Single-clock sequencer for the 8-point radix-2 pipelined FFT datapath.
//  - Accepts whole 8-sample frames through a valid/ready handshake.
//  - Drives the datapath input-register load and per-stage capture enables.
//  - Tracks an occupancy/tag bit per pipeline slot and raises out_valid in line with stage 3.
//  - Stalls the whole pipe, bubble-free, under output backpressure. Supports flush/drain.

---
 rtl/fft_pipe_sequencer_pkg.sv | 20 ++
 rtl/fft_pipe_sequencer_slot_reg.sv | 44 ++++
 rtl/fft_pipe_sequencer.sv | 127 ++++++++++++
 tb/tb_fft_pipe_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pipe_sequencer_pkg.sv
// fft_pipe_sequencer_pkg -- shared sizes and state encoding for the FFT pipe sequencer.
// Revision 1.0
`default_nettype none

package fft_pipe_sequencer_pkg;

  localparam int N_POINTS = 8;
  localparam int STAGES   = $clog2(N_POINTS);
  localparam int TAG_W    = 4;
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/fft_pipe_sequencer_slot_reg.sv
// fft_pipe_sequencer_slot_reg -- one pipeline slot: occupancy bit plus frame tag.
// Revision 1.0
`default_nettype none

module fft_pipe_sequencer_slot_reg
  import fft_pipe_sequencer_pkg::*;
(
  input  logic             clk_1,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             valid_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             valid,
  output logic [TAG_W-1:0] tag
);

  logic             valid_d, valid_q;
  logic [TAG_W-1:0] tag_d, tag_q;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (adv) begin
      valid_d = valid_in;
      tag_d   = tag_in;
    end
  end

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

  assign valid = valid_q;
  assign tag   = tag_q;

endmodule

`default_nettype wire

// File: rtl/fft_pipe_sequencer.sv
// fft_pipe_sequencer -- frame handshake, stage enables, stall ripple and flush FSM
// for the 8-point radix-2 pipelined FFT datapath. Revision 1.0
`default_nettype none

module fft_pipe_sequencer
  import fft_pipe_sequencer_pkg::*;
(
  input  logic              clk_1,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic              dp_load,
  output logic [STAGES-1:0] dp_stage_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy,
  output logic [CNT_W-1:0]  frames_done
);

  logic [STAGES:0]  v;
  logic [STAGES:0]  v_in;
  logic [STAGES:0]  v_next;
  logic [STAGES:0]  adv;
  logic [TAG_W-1:0] tag_slot [STAGES+1];
  logic [TAG_W-1:0] tag_in   [STAGES+1];

  seq_state_e       state_d, state_q;
  logic [TAG_W-1:0] tag_ctr_d, tag_ctr_q;
  logic [CNT_W-1:0] frames_done_d, frames_done_q;
  logic             out_fire;

  // Advance ripples back from the output: a slot moves if it is empty or its successor moves.
  always_comb begin
    adv[STAGES] = ~v[STAGES] | out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = ~v[k] | adv[k+1];
    end
  end

  assign in_ready = adv[0] & (state_q != ST_DRAIN) & ~flush;
  assign dp_load  = in_valid & in_ready;
  assign out_fire = v[STAGES] & out_ready;

  always_comb begin
    v_in[0]   = dp_load;
    tag_in[0] = tag_ctr_q;
    for (int k = 1; k <= STAGES; k++) begin
      v_in[k]   = v[k-1];
      tag_in[k] = tag_slot[k-1];
    end
    for (int k = 0; k <= STAGES; k++) begin
      v_next[k] = adv[k] ? v_in[k] : v[k];
    end
    for (int k = 0; k < STAGES; k++) begin
      dp_stage_en[k] = v[k] & adv[k+1];
    end
  end

  generate
    for (genvar i = 0; i <= STAGES; i++) begin : g_slot
      fft_pipe_sequencer_slot_reg u_slot (
        .clk_1    (clk_1),
        .rst_n    (rst_n),
        .adv      (adv[i]),
        .valid_in (v_in[i]),
        .tag_in   (tag_in[i]),
        .valid    (v[i]),
        .tag      (tag_slot[i])
      );
    end
  endgenerate

  always_comb begin
    state_d       = state_q;
    tag_ctr_d     = tag_ctr_q;
    frames_done_d = frames_done_q;
    if (dp_load) begin
      tag_ctr_d = tag_ctr_q + TAG_W'(1);
    end
    if (out_fire) begin
      frames_done_d = frames_done_q + CNT_W'(1);
    end
    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          if (|v) state_d = ST_DRAIN;
        end else if (dp_load) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_DRAIN;
        end else if (~(|v) && !dp_load) begin
          state_d = ST_IDLE;
        end
      end
      // Leave DRAIN on the edge that empties the pipe so busy drops right after the last handshake.
      ST_DRAIN: begin
        if (~(|v_next)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      tag_ctr_q     <= '0;
      frames_done_q <= '0;
    end else begin
      state_q       <= state_d;
      tag_ctr_q     <= tag_ctr_d;
      frames_done_q <= frames_done_d;
    end
  end

  assign out_valid   = v[STAGES];
  assign out_tag     = tag_slot[STAGES];
  assign busy        = (|v) | (state_q == ST_DRAIN);
  assign frames_done = frames_done_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_pipe_sequencer.sv
// tb_fft_pipe_sequencer -- directed and randomized checks of fft_pipe_sequencer
// against a slot-level behavioural model. Revision 1.0
`default_nettype none

module tb_fft_pipe_sequencer;
  import fft_pipe_sequencer_pkg::*;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic              clk_1;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic              dp_load;
  logic [STAGES-1:0] dp_stage_en;
  logic              out_valid;
  logic              out_ready;
  logic [TAG_W-1:0]  out_tag;
  logic              busy;
  logic [CNT_W-1:0]  frames_done;

  fft_pipe_sequencer dut (
    .clk_1       (clk_1),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .flush       (flush),
    .dp_load     (dp_load),
    .dp_stage_en (dp_stage_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_tag     (out_tag),
    .busy        (busy),
    .frames_done (frames_done)
  );

  initial clk_1 = 1'b0;
  always #5 clk_1 = ~clk_1;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b1;

  // Reference model: which slots hold a frame, the frame tags, FSM mode and counters.
  bit               mv [STAGES+1];
  logic [TAG_W-1:0] mt [STAGES+1];
  int               mst;
  logic [TAG_W-1:0] mtag;
  logic [CNT_W-1:0] mdone;
  logic [TAG_W-1:0] seen[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k <= STAGES; k++) begin
      mv[k] = 1'b0;
      mt[k] = '0;
    end
    mst   = M_IDLE;
    mtag  = '0;
    mdone = '0;
  endtask

  // One clock: predict outputs for the current inputs, compare, then move frames forward.
  task automatic step();
    bit               fr [STAGES+1];
    bit               nv [STAGES+1];
    logic [TAG_W-1:0] nt [STAGES+1];
    bit               ir, ld, ofire, anyv, anyn;
    logic [31:0]      se;
    #1;
    fr[STAGES] = !mv[STAGES] || out_ready;
    for (int k = STAGES - 1; k >= 0; k--) fr[k] = !mv[k] || fr[k+1];
    ir    = fr[0] && (mst != M_DRAIN) && !flush;
    ld    = in_valid && ir;
    ofire = mv[STAGES] && out_ready;
    se    = 0;
    anyv  = 1'b0;
    for (int k = 0; k < STAGES; k++) if (mv[k] && fr[k+1]) se[k] = 1'b1;
    for (int k = 0; k <= STAGES; k++) anyv |= mv[k];
    if (out_valid === 1'b1 && out_ready) seen.push_back(out_tag);
    if (chk_en) begin
      chk("in_ready", in_ready, ir);
      chk("dp_load", dp_load, ld);
      chk("dp_stage_en", dp_stage_en, se);
      chk("out_valid", out_valid, mv[STAGES]);
      if (mv[STAGES]) chk("out_tag", out_tag, mt[STAGES]);
      chk("busy", busy, anyv || mst == M_DRAIN);
      chk("frames_done", frames_done, mdone);
    end
    for (int k = STAGES; k >= 1; k--) begin
      nv[k] = fr[k] ? mv[k-1] : mv[k];
      nt[k] = fr[k] ? mt[k-1] : mt[k];
    end
    nv[0] = fr[0] ? ld : mv[0];
    nt[0] = fr[0] ? mtag : mt[0];
    anyn  = 1'b0;
    for (int k = 0; k <= STAGES; k++) anyn |= nv[k];
    case (mst)
      M_IDLE:  if (flush) begin if (anyv) mst = M_DRAIN; end else if (ld) mst = M_RUN;
      M_RUN:   if (flush) mst = M_DRAIN; else if (!anyv && !ld) mst = M_IDLE;
      default: if (!anyn) mst = M_IDLE;
    endcase
    if (ld) mtag = mtag + 1'b1;
    if (ofire) mdone = mdone + 1'b1;
    @(posedge clk_1);
    for (int k = 0; k <= STAGES; k++) begin
      mv[k] = nv[k];
      mt[k] = nt[k];
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frames_done", frames_done, 0);
    chk("rst_dp_load", dp_load, 0);
    chk("rst_dp_stage_en", dp_stage_en, 0);
    repeat (2) @(posedge clk_1);
    #3;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    int n;
    do_reset();

    // Single frame, unstalled
    out_ready = 1'b1;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      chk("t1_stage_en", dp_stage_en, 32'(1) << i);
      chk("t1_out_valid_low", out_valid, 0);
      step();
    end
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_tag", out_tag, 0);
    step();
    chk("t1_frames_done", frames_done, 1);
    chk("t1_out_valid_after", out_valid, 0);

    // Five back-to-back frames
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    seen.delete();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_in_ready", in_ready, 1);
      step();
    end
    in_valid = 1'b0;
    repeat (6) step();
    chk("t2_count", seen.size(), 5);
    for (int i = 0; i < seen.size(); i++) chk("t2_tag", seen[i], i);
    chk("t2_frames_done", frames_done, 5);

    // Backpressure: fill the pipe, stay frozen, then release
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (STAGES + 1) step();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_in_ready", in_ready, 0);
      chk("t3_stage_en", dp_stage_en, 0);
      chk("t3_out_valid", out_valid, 1);
      chk("t3_out_tag", out_tag, 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    seen.delete();
    repeat (6) step();
    chk("t3_count", seen.size(), 4);
    for (int i = 0; i < seen.size(); i++) chk("t3_tag", seen[i], i);

    // Flush after two frames with in_valid held
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    seen.delete();
    repeat (2) step();
    flush = 1'b1;
    #1;
    chk("t4_flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    n = 0;
    while (seen.size() < 2 && n < 20) begin
      #1;
      chk("t4_drain_in_ready", in_ready, 0);
      step();
      n++;
    end
    chk("t4_emitted", seen.size(), 2);
    chk("t4_busy_low", busy, 0);
    in_valid = 1'b0;
    #1;
    chk("t4_idle_in_ready", in_ready, 1);
    step();

    // Reset with frames in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (3) step();
    in_valid = 1'b0;
    repeat (2) step();
    chk("t5_pre_out_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_frames_done", frames_done, 0);
    @(posedge clk_1);
    #3;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seen.delete();
    repeat (8) step();
    chk("t5_nothing_emitted", seen.size(), 0);

    // Randomized traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      step();
    end
    flush = 1'b0;

    // Tag wrap over 17 frames
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    seen.delete();
    repeat (17) step();
    in_valid = 1'b0;
    repeat (6) step();
    chk("t6_count", seen.size(), 17);
    for (int i = 0; i < seen.size(); i++) chk("t6_tag", seen[i], i % 16);

    // frames_done wrap
    chk_en   = 1'b0;
    in_valid = 1'b1;
    n = 0;
    while (mdone != {CNT_W{1'b1}} && n < 70000) begin
      step();
      n++;
    end
    seen.delete();
    chk_en   = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("t6_done_max", frames_done, 32'hFFFF);
    chk("t6_out_valid", out_valid, 1);
    step();
    chk("t6_done_wrap", frames_done, 0);
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
